// File: rtl/sobel_raster_out_pkg.sv
// rtl/sobel_raster_out_pkg.sv - shared state encodings, marker struct and border helper
package sobel_raster_out_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } beat_marks_t;

  function automatic logic is_border(input int unsigned col, input int unsigned row,
                                     input int unsigned width, input int unsigned height);
    return (row == 0) || (row == height - 1) || (col == 0) || (col == width - 1);
  endfunction

endpackage

// File: rtl/sobel_result_fifo.sv
// rtl/sobel_result_fifo.sv - synchronous result FIFO; push+pop when full both succeed
module sobel_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // A push coincident with clear lands in slot 0 of the emptied FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= {{AW{1'b0}}, push};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear && push) begin
      r_mem[0] <= din;
    end else if (!clear && w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sobel_raster_out.sv
// rtl/sobel_raster_out.sv - rebuilds a full raster frame from interior Sobel results
module sobel_raster_out
  import sobel_raster_out_pkg::*;
#(
  parameter int                     IMG_WIDTH    = 640,
  parameter int                     IMG_HEIGHT   = 480,
  parameter int                     PIXEL_WIDTH  = 8,
  parameter int                     ADDR_WIDTH   = 10,
  parameter int                     FIFO_DEPTH   = 4,
  parameter logic [PIXEL_WIDTH-1:0] BORDER_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   in_valid,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   frame_done,
  output logic                   overflow
);

  logic [0:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_col;
  logic [ADDR_WIDTH-1:0]  r_row;
  logic                   r_eof_loaded;
  logic                   r_out_valid;
  logic [PIXEL_WIDTH-1:0] r_out_pixel;
  beat_marks_t            r_marks;
  logic                   r_frame_done;
  logic                   r_overflow;

  logic [PIXEL_WIDTH-1:0] w_fifo_dout;
  logic                   w_fifo_empty, w_fifo_full;
  logic                   w_active, w_border, w_col_last, w_row_last;
  logic                   w_handshake, w_frame_end, w_avail, w_load;
  logic                   w_pop, w_push, w_clear, w_drop;

  // r_col/r_row name the next beat to load into the output register.
  assign w_active    = (r_state == ST_ACTIVE);
  assign w_border    = is_border(32'(r_col), 32'(r_row), IMG_WIDTH, IMG_HEIGHT);
  assign w_col_last  = (r_col == ADDR_WIDTH'(IMG_WIDTH - 1));
  assign w_row_last  = (r_row == ADDR_WIDTH'(IMG_HEIGHT - 1));
  assign w_handshake = r_out_valid && out_ready;
  assign w_frame_end = w_handshake && r_marks.eof && !frame_start;
  assign w_avail     = w_active && !r_eof_loaded && (w_border || !w_fifo_empty);
  assign w_load      = (!r_out_valid || out_ready) && w_avail && !frame_start;
  assign w_pop       = w_load && !w_border;
  assign w_push      = in_valid && (frame_start || (w_active && !w_frame_end));
  assign w_clear     = frame_start || w_frame_end;
  assign w_drop      = (in_valid && !w_push)
                    || (w_push && !frame_start && w_fifo_full && !w_pop)
                    || (w_frame_end && !w_fifo_empty);

  sobel_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIXEL_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (w_clear),
    .din   (in_pixel),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_eof_loaded <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_pixel  <= '0;
      r_marks      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_drop) r_overflow <= 1'b1;
      if (frame_start) begin
        // Restart loads beat (0,0) directly, discarding whatever was pending.
        r_state      <= ST_ACTIVE;
        r_out_valid  <= 1'b1;
        r_out_pixel  <= BORDER_VALUE;
        r_marks      <= '{sof: 1'b1, eol: 1'b0, eof: 1'b0};
        r_col        <= ADDR_WIDTH'(1);
        r_row        <= '0;
        r_eof_loaded <= 1'b0;
      end else begin
        if (w_frame_end) begin
          r_state      <= ST_IDLE;
          r_eof_loaded <= 1'b0;
        end
        if (w_load) begin
          r_out_valid <= 1'b1;
          r_out_pixel <= w_border ? BORDER_VALUE : w_fifo_dout;
          r_marks     <= '{sof: (r_col == '0) && (r_row == '0),
                           eol: w_col_last,
                           eof: w_col_last && w_row_last};
          if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + 1'b1;
            if (w_row_last) r_eof_loaded <= 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end else if (w_handshake) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_pixel  = r_out_pixel;
  assign out_sof    = r_marks.sof;
  assign out_eol    = r_marks.eol;
  assign out_eof    = r_marks.eof;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_sobel_raster_out.sv
// tb/tb_sobel_raster_out.sv - scoreboard bench for sobel_raster_out on a 5x4 frame
module tb_sobel_raster_out;

  localparam int W = 5;
  localparam int H = 4;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_frame_start, a_in_valid, a_out_ready;
  logic [7:0] a_in_pixel, a_out_pixel;
  logic       a_out_valid, a_out_sof, a_out_eol, a_out_eof, a_frame_done, a_overflow;
  logic       b_frame_start, b_in_valid, b_out_ready;
  logic [7:0] b_in_pixel, b_out_pixel;
  logic       b_out_valid, b_out_sof, b_out_eol, b_out_eof, b_frame_done, b_overflow;

  sobel_raster_out #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .ADDR_WIDTH(10),
    .FIFO_DEPTH(8), .BORDER_VALUE(8'h00)
  ) dut_a (
    .clk(clk), .rst(rst), .frame_start(a_frame_start), .in_valid(a_in_valid),
    .in_pixel(a_in_pixel), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pixel(a_out_pixel), .out_sof(a_out_sof), .out_eol(a_out_eol),
    .out_eof(a_out_eof), .frame_done(a_frame_done), .overflow(a_overflow)
  );

  sobel_raster_out #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .ADDR_WIDTH(10),
    .FIFO_DEPTH(2), .BORDER_VALUE(8'h00)
  ) dut_b (
    .clk(clk), .rst(rst), .frame_start(b_frame_start), .in_valid(b_in_valid),
    .in_pixel(b_in_pixel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pixel(b_out_pixel), .out_sof(b_out_sof), .out_eol(b_out_eol),
    .out_eof(b_out_eof), .frame_done(b_frame_done), .overflow(b_overflow)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    a_beats = 0;
  int    a_dones = 0;
  int    b_beats = 0;
  int    b_dones = 0;
  logic [7:0] b_pix [32];
  int    cyc = 0;
  int    rmode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rmode)
      0:       a_out_ready = 1'b1;
      1:       a_out_ready = cyc[0];
      default: a_out_ready = 1'b0;
    endcase
  endtask

  task automatic push_frame(input logic [7:0] v [6], input int n);
    int idx = 0;
    int k = 0;
    beat_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          e.pix = 8'h00;
        end else begin
          e.pix = v[idx];
          idx++;
        end
        e.sof = (r == 0 && c == 0);
        e.eol = (c == W - 1);
        e.eof = (r == H - 1 && c == W - 1);
        if (k < n) exp_q.push_back(e);
        k++;
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (a_dones < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_reached", 32'(a_dones >= target), 32'd1);
  endtask

  // Scoreboard monitor for dut_a: beat order/content, hold-while-stalled, frame_done pulse.
  initial begin
    beat_t cur, held, e;
    logic  held_v = 1'b0;
    logic  prev_fs = 1'b0;
    logic  exp_done = 1'b0;
    forever begin
      @(negedge clk);
      cur = '{pix: a_out_pixel, sof: a_out_sof, eol: a_out_eol, eof: a_out_eof};
      if (rst) begin
        held_v = 1'b0;
        exp_done = 1'b0;
      end else begin
        if (exp_done) begin
          chk("frame_done_pulse", 32'(a_frame_done), 32'd1);
          a_dones++;
          exp_done = 1'b0;
        end else if (a_frame_done) begin
          chk("frame_done_spurious", 32'(a_frame_done), 32'd0);
        end
        if (held_v && !prev_fs) begin
          chk("hold_valid", 32'(a_out_valid), 32'd1);
          chk("hold_beat", 32'(cur), 32'(held));
        end
        if (a_out_valid && a_out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("beat%0d", a_beats), 32'(cur), 32'(e));
          end
          a_beats++;
          if (cur.eof) exp_done = 1'b1;
        end
        held_v = a_out_valid && !a_out_ready;
        held = cur;
        prev_fs = a_frame_start;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (b_out_valid && b_out_ready) begin
          if (b_beats < 32) b_pix[b_beats] = b_out_pixel;
          b_beats++;
        end
        if (b_frame_done) b_dones++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v1 [6];
    logic [7:0] v2 [6];
    logic [7:0] v3 [6];
    logic [7:0] v4 [6];
    logic [7:0] bvals [4];
    int base;
    int n;
    v1 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    v2 = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
    v3 = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    v4 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    bvals = '{8'hB4, 8'hB5, 8'hB6, 8'hB7};
    rst = 1'b1;
    a_frame_start = 1'b0; a_in_valid = 1'b0; a_in_pixel = 8'h00; a_out_ready = 1'b1;
    b_frame_start = 1'b0; b_in_valid = 1'b0; b_in_pixel = 8'h00; b_out_ready = 1'b0;
    tick(); tick(); tick();
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_markers", {29'd0, a_out_sof, a_out_eol, a_out_eof}, 32'd0);
    chk("rst_overflow", 32'(a_overflow), 32'd0);
    chk("rst_pixel", 32'(a_out_pixel), 32'd0);
    rst = 1'b0;
    tick();

    // Frame 1: ready held high.
    push_frame(v1, 20);
    a_frame_start = 1'b1;
    tick();
    a_frame_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1; a_in_pixel = v1[i];
      tick();
    end
    a_in_valid = 1'b0;
    wait_done(1, 100);
    chk("f1_beats", 32'(a_beats), 32'd20);
    chk("f1_overflow", 32'(a_overflow), 32'd0);

    // Frame 2: same data, ready toggling.
    tick();
    rmode = 1;
    push_frame(v1, 20);
    a_frame_start = 1'b1;
    tick();
    a_frame_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1; a_in_pixel = v1[i];
      tick();
    end
    a_in_valid = 1'b0;
    wait_done(2, 200);
    chk("f2_beats", 32'(a_beats), 32'd40);
    rmode = 0;
    tick();

    // Restart mid-frame at beat 8, with in_valid coincident with frame_start.
    base = a_beats;
    push_frame(v2, 8);
    a_frame_start = 1'b1;
    tick();
    a_frame_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1; a_in_pixel = v2[i];
      tick();
    end
    a_in_valid = 1'b0;
    tick();
    rmode = 2;
    tick();
    chk("restart_beats_before", 32'(a_beats - base), 32'd8);
    chk("restart_pending_valid", 32'(a_out_valid), 32'd1);
    push_frame(v3, 20);
    a_frame_start = 1'b1; a_in_valid = 1'b1; a_in_pixel = v3[0];
    rmode = 0;
    tick();
    a_frame_start = 1'b0;
    for (int i = 1; i < 6; i++) begin
      a_in_valid = 1'b1; a_in_pixel = v3[i];
      tick();
    end
    a_in_valid = 1'b0;
    wait_done(3, 200);
    chk("restart_total_beats", 32'(a_beats - base), 32'd28);
    chk("restart_overflow", 32'(a_overflow), 32'd0);
    tick();

    // Late inputs: stall at (1,1); first interior beat two cycles after its push.
    push_frame(v4, 20);
    a_frame_start = 1'b1;
    tick();
    a_frame_start = 1'b0;
    repeat (6) tick();
    chk("late_stall_at_1_1", 32'(a_out_valid), 32'd0);
    tick(); tick();
    a_in_valid = 1'b1; a_in_pixel = v4[0];
    tick();
    chk("late_push_plus1_valid", 32'(a_out_valid), 32'd0);
    a_in_pixel = v4[1];
    tick();
    chk("late_push_plus2_valid", 32'(a_out_valid), 32'd1);
    chk("late_push_plus2_pixel", 32'(a_out_pixel), 32'h31);
    for (int i = 2; i < 6; i++) begin
      a_in_pixel = v4[i];
      tick();
    end
    a_in_valid = 1'b0;
    wait_done(4, 200);
    chk("late_overflow", 32'(a_overflow), 32'd0);

    // in_valid while IDLE, then rst.
    tick();
    a_in_valid = 1'b1; a_in_pixel = 8'h99;
    tick();
    a_in_valid = 1'b0;
    chk("idle_push_overflow", 32'(a_overflow), 32'd1);
    chk("idle_push_no_beat", 32'(a_out_valid), 32'd0);
    repeat (3) tick();
    chk("idle_overflow_sticky", 32'(a_overflow), 32'd1);
    chk("idle_still_no_beat", 32'(a_out_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("rst2_overflow", 32'(a_overflow), 32'd0);
    chk("rst2_outputs", {22'd0, a_out_valid, a_out_pixel, a_frame_done},  32'd0);
    chk("rst2_markers", {29'd0, a_out_sof, a_out_eol, a_out_eof}, 32'd0);
    rst = 1'b0;
    tick();

    // dut_b (FIFO_DEPTH=2): third push while stalled is dropped.
    b_out_ready = 1'b1;
    b_frame_start = 1'b1;
    tick();
    b_frame_start = 1'b0;
    tick();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_pixel = 8'hB1;
    tick();
    b_in_pixel = 8'hB2;
    tick();
    b_in_pixel = 8'hB3;
    chk("b_overflow_before_drop", 32'(b_overflow), 32'd0);
    tick();
    b_in_valid = 1'b0;
    chk("b_overflow_after_drop", 32'(b_overflow), 32'd1);
    b_out_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1; b_in_pixel = bvals[i];
      tick();
      b_in_valid = 1'b0;
      tick(); tick();
    end
    n = 0;
    while (b_dones == 0 && n < 200) begin
      tick();
      n++;
    end
    chk("b_frame_done", 32'(b_dones), 32'd1);
    chk("b_overflow_sticky", 32'(b_overflow), 32'd1);
    chk("b_beats", 32'(b_beats), 32'd20);
    chk("b_pix0", 32'(b_pix[0]), 32'h00);
    chk("b_pix5", 32'(b_pix[5]), 32'h00);
    chk("b_pix6", 32'(b_pix[6]), 32'hB1);
    chk("b_pix7", 32'(b_pix[7]), 32'hB2);
    chk("b_pix8", 32'(b_pix[8]), 32'hB4);
    chk("b_pix11", 32'(b_pix[11]), 32'hB5);
    chk("b_pix12", 32'(b_pix[12]), 32'hB6);
    chk("b_pix13", 32'(b_pix[13]), 32'hB7);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
